// File: rtl/nv_ram_fifo_pkg.sv
// Shared sizing constants for the nv_ram_fifo controller family.
// Sibling RAM sizes reuse this package with their own depth and width.
package nv_ram_fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_WIDTH = 129;
    localparam int FIFO_AW    = 3;

    // The occupancy counters are one bit wider than a pointer so they can reach the full depth.
    localparam logic [FIFO_AW:0]   USED_FULL = 4'd8;
    localparam logic [FIFO_AW-1:0] PTR_ONE   = 3'd1;

endpackage

// File: rtl/nv_ram_fifo_ctl_8x129.sv
// Flow-control wrapper for an external 8x129 RAM whose read takes two steps: re latches the address, ore registers the data.
// The read pipe is S1 (address held in the RAM) followed by S2 (data held in the RAM output register).
module nv_ram_fifo_ctl_8x129
    import nv_ram_fifo_pkg::*;
(
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  wr_pvld,
    output logic                  wr_prdy,
    input  logic [FIFO_WIDTH-1:0] wr_pd,
    output logic                  rd_pvld,
    input  logic                  rd_prdy,
    output logic [FIFO_WIDTH-1:0] rd_pd,
    output logic                  ram_we,
    output logic [FIFO_AW-1:0]    ram_wa,
    output logic [FIFO_WIDTH-1:0] ram_di,
    output logic                  ram_re,
    output logic [FIFO_AW-1:0]    ram_ra,
    output logic                  ram_ore,
    input  logic [FIFO_WIDTH-1:0] ram_dout,
    output logic [FIFO_AW:0]      fifo_cnt,
    output logic                  idle,
    input  logic [31:0]           pwrbus_in,
    output logic [31:0]           ram_pwrbus_pd
);

    // Handshake rule on both ports: a beat transfers on a rising edge where valid and ready
    // are both high. Valid never depends on ready. wr_prdy comes from registered state only.
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   avail;
    logic [FIFO_AW:0]   ram_used;
    logic               s1_vld;
    logic               s2_vld;

    logic               wr_accept;
    logic               ore_fire;
    logic               re_fire;
    logic               pop;
    logic [FIFO_AW:0]   avail_nxt;
    logic [FIFO_AW:0]   used_nxt;
    logic               s1_nxt;
    logic               s2_nxt;

    always_comb begin
        wr_accept = wr_pvld & wr_prdy;
        ore_fire  = s1_vld & (~s2_vld | rd_prdy);
        // S1 may be refilled only when it is empty or is emptying this cycle.
        // A stalled S1 therefore keeps its address in the RAM.
        re_fire   = (avail != '0) & (~s1_vld | ore_fire);
        pop       = s2_vld & rd_prdy;
        avail_nxt = avail + {{FIFO_AW{1'b0}}, wr_accept} - {{FIFO_AW{1'b0}}, re_fire};
        used_nxt  = ram_used + {{FIFO_AW{1'b0}}, wr_accept} - {{FIFO_AW{1'b0}}, ore_fire};
        s1_nxt    = re_fire | (s1_vld & ~ore_fire);
        s2_nxt    = ore_fire | (s2_vld & ~pop);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            avail    <= '0;
            ram_used <= '0;
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (wr_accept) wptr <= wptr + PTR_ONE;
            if (re_fire)   rptr <= rptr + PTR_ONE;
            avail    <= avail_nxt;
            ram_used <= used_nxt;
            s1_vld   <= s1_nxt;
            s2_vld   <= s2_nxt;
            fifo_cnt <= used_nxt + {{FIFO_AW{1'b0}}, s2_nxt};
        end
    end

    // An entry sitting in S2 has already left the RAM, so a full RAM plus S2 holds nine entries.
    assign wr_prdy       = (ram_used != USED_FULL);
    assign rd_pvld       = s2_vld;
    assign rd_pd         = ram_dout;
    assign ram_we        = wr_accept;
    assign ram_wa        = wptr;
    assign ram_di        = wr_pd;
    assign ram_re        = re_fire;
    assign ram_ra        = rptr;
    assign ram_ore       = ore_fire;
    assign idle          = (fifo_cnt == '0);
    assign ram_pwrbus_pd = pwrbus_in;

endmodule

// File: tb/tb_nv_ram_fifo_ctl_8x129.sv
// Bench for nv_ram_fifo_ctl_8x129: a behavioural two-step RAM, an order-preserving queue scoreboard and scenario tasks.
module tb_nv_ram_fifo_ctl_8x129;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_pvld = 1'b0;
    logic         wr_prdy;
    logic [128:0] wr_pd = '0;
    logic         rd_pvld;
    logic         rd_prdy = 1'b0;
    logic [128:0] rd_pd;
    logic         ram_we;
    logic [2:0]   ram_wa;
    logic [128:0] ram_di;
    logic         ram_re;
    logic [2:0]   ram_ra;
    logic         ram_ore;
    logic [128:0] ram_dout;
    logic [3:0]   fifo_cnt;
    logic         idle;
    logic [31:0]  pwrbus_in = '0;
    logic [31:0]  ram_pwrbus_pd;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    nv_ram_fifo_ctl_8x129 dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .wr_pvld(wr_pvld),
        .wr_prdy(wr_prdy),
        .wr_pd(wr_pd),
        .rd_pvld(rd_pvld),
        .rd_prdy(rd_prdy),
        .rd_pd(rd_pd),
        .ram_we(ram_we),
        .ram_wa(ram_wa),
        .ram_di(ram_di),
        .ram_re(ram_re),
        .ram_ra(ram_ra),
        .ram_ore(ram_ore),
        .ram_dout(ram_dout),
        .fifo_cnt(fifo_cnt),
        .idle(idle),
        .pwrbus_in(pwrbus_in),
        .ram_pwrbus_pd(ram_pwrbus_pd)
    );

    // ---------------- RAM model: address captured on re, data registered on ore ----------------
    logic [128:0] mem [8];
    logic [2:0]   ra_d;
    logic [128:0] dout_r;

    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_d <= ram_ra;
        if (ram_ore) dout_r <= mem[ra_d];
    end
    assign ram_dout = dout_r;

    // ---------------- scoreboard: FIFO order and occupancy ----------------
    logic [128:0] exp_q[$];
    int           mdl_cnt = 0;
    logic         s1_busy = 1'b0;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_q.delete();
            mdl_cnt = 0;
            s1_busy = 1'b0;
        end else begin
            checks++; if (fifo_cnt !== 4'(mdl_cnt)) begin errors++; $display("FAIL sb_fifo_cnt got=%0d exp=%0d", fifo_cnt, mdl_cnt); end
            checks++; if (idle !== (mdl_cnt == 0)) begin errors++; $display("FAIL sb_idle got=%b exp=%b", idle, (mdl_cnt == 0)); end
            checks++;
            if ((mdl_cnt <= 7 && wr_prdy !== 1'b1) || (mdl_cnt >= 9 && wr_prdy !== 1'b0)) begin
                errors++; $display("FAIL sb_wr_prdy got=%b with %0d entries held", wr_prdy, mdl_cnt);
            end
            checks++; if (ram_we !== (wr_pvld & wr_prdy)) begin errors++; $display("FAIL sb_ram_we got=%b exp=%b", ram_we, wr_pvld & wr_prdy); end
            if (ram_re === 1'b1) begin
                checks++; if (s1_busy && ram_ore !== 1'b1) begin errors++; $display("FAIL sb_re_while_s1_stalled got re=1 exp re=0"); end
            end
            if (ram_ore === 1'b1) begin
                checks++; if (!s1_busy) begin errors++; $display("FAIL sb_ore_without_addr got ore=1 exp ore=0"); end
                checks++; if (rd_pvld === 1'b1 && rd_prdy !== 1'b1) begin errors++; $display("FAIL sb_ore_over_held_data got ore=1 exp ore=0"); end
            end
            if (wr_pvld && wr_prdy) begin
                exp_q.push_back(wr_pd);
                mdl_cnt++;
            end
            if (rd_pvld && rd_prdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_pop_empty got data=%h exp none", rd_pd);
                end else begin
                    logic [128:0] e;
                    e = exp_q.pop_front();
                    if (rd_pd !== e) begin errors++; $display("FAIL sb_data got=%h exp=%h", rd_pd, e); end
                end
                mdl_cnt--;
                n_pop++;
            end
            checks++; if (mdl_cnt > 9) begin errors++; $display("FAIL sb_overfill got=%0d exp<=9", mdl_cnt); end
            s1_busy = ram_re | (s1_busy & ~ram_ore);
        end
    end

    function automatic logic [128:0] rand_pd();
        return {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pwrbus_in = $urandom;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL rst_wr_prdy got=%b exp=1", wr_prdy); end
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL rst_rd_pvld got=%b exp=0", rd_pvld); end
        checks++; if ({ram_we, ram_re, ram_ore} !== 3'b000) begin errors++; $display("FAIL rst_ram_en got=%b exp=000", {ram_we, ram_re, ram_ore}); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL rst_fifo_cnt got=%0d exp=0", fifo_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
        checks++; if (ram_pwrbus_pd !== pwrbus_in) begin errors++; $display("FAIL pwrbus got=%h exp=%h", ram_pwrbus_pd, pwrbus_in); end
        @(negedge clk);
        rst = 1'b0;
        pwrbus_in = $urandom;
        #1;
        checks++; if (ram_pwrbus_pd !== pwrbus_in) begin errors++; $display("FAIL pwrbus2 got=%h exp=%h", ram_pwrbus_pd, pwrbus_in); end
        checks++; if (wr_prdy !== 1'b1 || fifo_cnt !== 4'd0) begin errors++; $display("FAIL post_rst got prdy=%b cnt=%0d exp prdy=1 cnt=0", wr_prdy, fifo_cnt); end
    endtask

    task automatic test_single_latency();
        logic [128:0] d;
        d = 129'h1_DEAD_BEEF;
        @(negedge clk);
        wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_wa !== 3'd0 || ram_di !== d) begin errors++; $display("FAIL lat_write got we=%b wa=%0d exp we=1 wa=0", ram_we, ram_wa); end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++; if (ram_re !== 1'b1 || ram_ra !== 3'd0 || ram_ore !== 1'b0 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL lat_n1 got re=%b ra=%0d ore=%b vld=%b exp re=1 ra=0 ore=0 vld=0", ram_re, ram_ra, ram_ore, rd_pvld);
        end
        @(negedge clk); #1;
        checks++; if (ram_ore !== 1'b1 || ram_re !== 1'b0 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL lat_n2 got ore=%b re=%b vld=%b exp ore=1 re=0 vld=0", ram_ore, ram_re, rd_pvld);
        end
        @(negedge clk); #1;
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== d || fifo_cnt !== 4'd1) begin
            errors++; $display("FAIL lat_n3 got vld=%b pd=%h cnt=%0d exp vld=1 pd=%h cnt=1", rd_pvld, rd_pd, fifo_cnt, d);
        end
        @(negedge clk); #1;
        checks++; if (rd_pvld !== 1'b0 || fifo_cnt !== 4'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL lat_drain got vld=%b cnt=%0d idle=%b exp 0 0 1", rd_pvld, fifo_cnt, idle);
        end
    endtask

    task automatic test_fill_full_pop();
        int acc;
        acc = 0;
        rd_prdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_pvld = 1'b1; wr_pd = rand_pd();
            #1;
            if (wr_prdy) acc++;
        end
        checks++; if (acc != 9) begin errors++; $display("FAIL fill_accepts got=%0d exp=9", acc); end
        checks++; if (fifo_cnt !== 4'd9 || wr_prdy !== 1'b0) begin errors++; $display("FAIL fill_full got cnt=%0d prdy=%b exp cnt=9 prdy=0", fifo_cnt, wr_prdy); end
        @(negedge clk);
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = rand_pd();
        #1;
        checks++; if (wr_prdy !== 1'b0 || rd_pvld !== 1'b1) begin errors++; $display("FAIL full_pop_cycle got prdy=%b vld=%b exp prdy=0 vld=1", wr_prdy, rd_pvld); end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL full_next_accept got prdy=%b exp=1", wr_prdy); end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++; if (fifo_cnt !== 4'd9) begin errors++; $display("FAIL full_refill got cnt=%0d exp=9", fifo_cnt); end
        rd_prdy = 1'b1;
        for (int i = 0; i < 40 && fifo_cnt != 4'd0; i++) begin
            @(negedge clk); #1;
        end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL full_drain got cnt=%0d exp=0", fifo_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            wr_pvld = (c < 20); wr_pd = 129'(c); rd_prdy = 1'b1;
            #1;
            if (c < 20) begin
                checks++; if (ram_we !== 1'b1 || ram_wa !== 3'(c % 8)) begin errors++; $display("FAIL b2b_write c=%0d got we=%b wa=%0d exp we=1 wa=%0d", c, ram_we, ram_wa, c % 8); end
            end
            checks++;
            if (c >= 1 && c <= 20) begin
                if (ram_re !== 1'b1 || ram_ra !== 3'((c - 1) % 8)) begin errors++; $display("FAIL b2b_re c=%0d got re=%b ra=%0d exp re=1 ra=%0d", c, ram_re, ram_ra, (c - 1) % 8); end
            end else if (ram_re !== 1'b0) begin
                errors++; $display("FAIL b2b_re_idle c=%0d got re=%b exp=0", c, ram_re);
            end
            checks++;
            if (c >= 3 && c <= 22) begin
                if (rd_pvld !== 1'b1 || rd_pd !== 129'(c - 3)) begin errors++; $display("FAIL b2b_read c=%0d got vld=%b pd=%0d exp vld=1 pd=%0d", c, rd_pvld, rd_pd, c - 3); end
            end else if (rd_pvld !== 1'b0) begin
                errors++; $display("FAIL b2b_read_idle c=%0d got vld=%b exp=0", c, rd_pvld);
            end
        end
    endtask

    task automatic test_random_stalls();
        int written;
        int pop0;
        int cyc;
        written = 0;
        pop0 = n_pop;
        cyc = 0;
        while ((written < 1000 || fifo_cnt != 4'd0) && cyc < 20000) begin
            @(negedge clk);
            wr_pvld = (written < 1000) && ($urandom_range(0, 99) < 70);
            wr_pd = rand_pd();
            rd_prdy = ($urandom_range(0, 99) < 60);
            #1;
            if (wr_pvld && wr_prdy) written++;
            cyc++;
        end
        @(negedge clk);
        wr_pvld = 1'b0; rd_prdy = 1'b0;
        #4;
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout got cycles=%0d exp<20000", cyc); end
        checks++; if (n_pop - pop0 != 1000) begin errors++; $display("FAIL rand_pop_count got=%0d exp=1000", n_pop - pop0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [128:0] d;
        rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_pvld = 1'b1; wr_pd = rand_pd();
        end
        @(negedge clk);
        wr_pvld = 1'b0;
        for (int i = 0; i < 10 && fifo_cnt != 4'd5; i++) begin
            @(negedge clk);
        end
        #1;
        checks++; if (fifo_cnt !== 4'd5) begin errors++; $display("FAIL mid_precnt got=%0d exp=5", fifo_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (wr_prdy !== 1'b1 || rd_pvld !== 1'b0 || fifo_cnt !== 4'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL mid_rst got prdy=%b vld=%b cnt=%0d idle=%b exp 1 0 0 1", wr_prdy, rd_pvld, fifo_cnt, idle);
        end
        checks++; if ({ram_we, ram_re, ram_ore} !== 3'b000) begin errors++; $display("FAIL mid_rst_ram got=%b exp=000", {ram_we, ram_re, ram_ore}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d = rand_pd();
        @(negedge clk);
        wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        for (int i = 0; i < 10 && rd_pvld !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== d) begin errors++; $display("FAIL mid_new_data got vld=%b pd=%h exp vld=1 pd=%h", rd_pvld, rd_pd, d); end
        @(negedge clk); #1;
        checks++; if (rd_pvld !== 1'b0 || fifo_cnt !== 4'd0) begin errors++; $display("FAIL mid_no_old got vld=%b cnt=%0d exp vld=0 cnt=0", rd_pvld, fifo_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        do_reset();
        test_single_latency();
        test_fill_full_pop();
        do_reset();
        test_back_to_back();
        test_random_stalls();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
